pio_poll_ctrl: RTL and testbench

Avalon-MM polling controller that sequences the 4-bit input PIO: it periodically reads the PIO data register and debounces the sampled value. It captures rising/falling changes into a sticky edge register and raises a maskable interrupt. It sits between the PIO's s1 slave (as its only master) and the CPU data bus (as a small register slave), so software sees clean, debounced inputs without busy-polling the raw port.

---
 rtl/pio_poll_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pio_poll_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_poll_ctrl.sv
`timescale 1ns/1ps
// pio_poll_ctrl
//   Avalon-MM polling controller for a small input PIO. It periodically reads the
//   PIO data register, debounces the sampled value and records debounced changes
//   in a sticky edge register that drives a maskable, level interrupt.
//
// Ports
//   clk, reset_n      system clock, asynchronous active-low reset
//   m_address/m_read  master side towards the PIO s1 slave (address always 0)
//   m_readdata        PIO read data, registered by the PIO (valid cycle after m_read)
//   s_address/s_read/s_write/s_writedata/s_readdata
//                     CPU register slave, read latency 1
//                     0 STATE (RO), 1 EDGE (W1C), 2 MASK (RW), 3 CTRL bit0 ENABLE (RW)
//   irq               high while (EDGE & MASK) != 0, registered
module pio_poll_ctrl #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned POLL_DIV   = 50000,
    parameter int unsigned STABLE_CNT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  m_address,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        irq
);

    localparam int unsigned DivW = 24;
    // WAIT covers POLL_DIV-3 cycles; ISSUE/CAPTURE/UPDATE make up the rest of the period.
    localparam logic [DivW-1:0] DivReload = DivW'(POLL_DIV - 4);
    localparam logic [3:0]      StableMax = 4'(STABLE_CNT);

    typedef enum logic [1:0] {
        StWait,
        StIssue,
        StCapture,
        StUpdate
    } state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [WIDTH-1:0]  sample_q;
    logic [WIDTH-1:0]  cand_q, cand_d;
    logic [3:0]        stab_q, stab_d;
    logic [WIDTH-1:0]  value_q, value_d;
    logic [WIDTH-1:0]  edge_q, edge_d;
    logic [WIDTH-1:0]  mask_q;
    logic              enable_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              irq_q;
    logic              accept;

    // Only the low WIDTH bits of the data buses carry information.
    logic unused_bits;
    assign unused_bits = ^{m_readdata, s_writedata};

    // Poll sequencer
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        case (state_q)
            StWait: begin
                if (!enable_q) begin
                    div_d = DivReload;
                end else if (div_q == '0) begin
                    state_d = StIssue;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            StIssue:   state_d = StCapture;
            StCapture: state_d = StUpdate;
            StUpdate: begin
                state_d = StWait;
                div_d   = DivReload;
            end
            default:   state_d = StWait;
        endcase
    end

    // Debounce: stab counts consecutive identical samples of cand, saturating.
    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        accept = 1'b0;
        if (state_q == StUpdate) begin
            if (sample_q != cand_q) begin
                cand_d = sample_q;
                stab_d = 4'd1;
            end else if (stab_q < StableMax) begin
                stab_d = stab_q + 4'd1;
            end
            accept = (stab_d == StableMax);
        end
    end

    // STATE/EDGE: W1C clear applied first so a same-cycle debounced change wins.
    always_comb begin
        value_d = value_q;
        edge_d  = edge_q;
        if (s_write && (s_address == 2'd1)) begin
            edge_d = edge_q & ~s_writedata[WIDTH-1:0];
        end
        if (accept && (cand_d != value_q)) begin
            value_d = cand_d;
            edge_d  = edge_d | (value_q ^ cand_d);
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (s_read) begin
            case (s_address)
                2'd0:    rdata_d = 32'(value_q);
                2'd1:    rdata_d = 32'(edge_q);
                2'd2:    rdata_d = 32'(mask_q);
                default: rdata_d = 32'(enable_q);
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StWait;
            div_q    <= DivReload;
            sample_q <= '0;
            cand_q   <= '0;
            stab_q   <= '0;
            value_q  <= '0;
            edge_q   <= '0;
            mask_q   <= '0;
            enable_q <= 1'b1;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            if (state_q == StCapture) begin
                sample_q <= m_readdata[WIDTH-1:0];
            end
            cand_q  <= cand_d;
            stab_q  <= stab_d;
            value_q <= value_d;
            edge_q  <= edge_d;
            if (s_write && (s_address == 2'd2)) begin
                mask_q <= s_writedata[WIDTH-1:0];
            end
            if (s_write && (s_address == 2'd3)) begin
                enable_q <= s_writedata[0];
            end
            rdata_q <= rdata_d;
            irq_q   <= |(edge_q & mask_q);
        end
    end

    assign m_read     = (state_q == StIssue);
    assign m_address  = 2'b00;
    assign s_readdata = rdata_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_pio_poll_ctrl.sv
`timescale 1ns/1ps
// tb_pio_poll_ctrl
//   Directed scenarios with literal expectations followed by randomized bus and
//   input traffic, all compared every cycle against a schedule/queue based model.
module tb_pio_poll_ctrl;

    localparam int WIDTH      = 4;
    localparam int POLL_DIV   = 8;
    localparam int STABLE_CNT = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  m_address;
    logic        m_read;
    logic [31:0] pio_q = '0;
    logic [1:0]  s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        irq;
    logic [3:0]  in_port;

    int n_tests = 0;
    int n_fail  = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    pio_poll_ctrl #(
        .WIDTH      (WIDTH),
        .POLL_DIV   (POLL_DIV),
        .STABLE_CNT (STABLE_CNT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .m_address   (m_address),
        .m_read      (m_read),
        .m_readdata  (pio_q),
        .s_address   (s_address),
        .s_read      (s_read),
        .s_write     (s_write),
        .s_writedata (s_writedata),
        .s_readdata  (s_readdata),
        .irq         (irq)
    );

    // PIO data register: registered read data with junk in the unused upper bits.
    always @(posedge clk) begin
        if (m_read) pio_q <= {28'($urandom()), in_port};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          cyc;       // edges since reset release
    int          issue_at;  // cycle in which the latest poll read was issued
    int          ready_at;  // earliest cycle the next poll may issue
    logic [3:0]  m_state, m_edge, m_mask, m_samp;
    logic        m_en, m_irq;
    logic [31:0] m_rdata;
    logic [3:0]  hist[$];   // most recent STABLE_CNT poll samples

    task automatic model_reset();
        cyc      = 0;
        issue_at = -100;
        ready_at = POLL_DIV - 3;
        m_state  = '0;
        m_edge   = '0;
        m_mask   = '0;
        m_samp   = '0;
        m_en     = 1'b1;
        m_irq    = 1'b0;
        m_rdata  = '0;
        hist.delete();
    endtask

    task automatic model_step();
        int          e;
        logic [3:0]  n_st, n_ed, n_mk;
        logic        n_en;
        logic [31:0] n_rd;
        bit          eq;
        e    = cyc + 1;
        n_st = m_state;
        n_ed = m_edge;
        n_mk = m_mask;
        n_en = m_en;
        n_rd = m_rdata;
        if (s_read) begin
            case (s_address)
                2'd0:    n_rd = 32'(m_state);
                2'd1:    n_rd = 32'(m_edge);
                2'd2:    n_rd = 32'(m_mask);
                default: n_rd = 32'(m_en);
            endcase
        end
        if (s_write) begin
            case (s_address)
                2'd1:    n_ed = m_edge & ~s_writedata[3:0];
                2'd2:    n_mk = s_writedata[3:0];
                2'd3:    n_en = s_writedata[0];
                default: ;
            endcase
        end
        if (e == issue_at + 1) m_samp = in_port;
        if (e == issue_at + 3) begin
            hist.push_back(m_samp);
            if (hist.size() > STABLE_CNT) hist.delete(0);
            eq = 1'b1;
            foreach (hist[i]) if (hist[i] != hist[0]) eq = 1'b0;
            if (hist.size() == STABLE_CNT && eq && hist[0] != m_state) begin
                n_ed = n_ed | (m_state ^ hist[0]);
                n_st = hist[0];
            end
            ready_at = e + POLL_DIV - 3;
        end else if (e > issue_at + 3) begin
            if (!m_en) ready_at = e + POLL_DIV - 3;
            else if (e >= ready_at) issue_at = e;
        end
        m_irq   = |(m_edge & m_mask);
        m_state = n_st;
        m_edge  = n_ed;
        m_mask  = n_mk;
        m_en    = n_en;
        m_rdata = n_rd;
        cyc     = e;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (run_cmp && reset_n === 1'b1) begin
            check("m_read", 32'(m_read), 32'(cyc == issue_at));
            check("m_address", 32'(m_address), 32'd0);
            check("irq", 32'(irq), 32'(m_irq));
            check("s_readdata", s_readdata, m_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        s_read    = 1'b1;
        s_address = a;
        @(negedge clk);
        d = s_readdata;
        #1;
        s_read = 1'b0;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        s_write     = 1'b1;
        s_address   = a;
        s_writedata = d;
        @(negedge clk);
        #1;
        s_write = 1'b0;
    endtask

    task automatic rd_check(input string nm, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(a, d);
        check(nm, d, exp);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    // m_read expected exactly at first, first+POLL_DIV, ...
    task automatic mread_until(input int last, input int first);
        while (cyc < last) begin
            tick();
            check("m_read_sched", 32'(m_read),
                  32'(cyc >= first && ((cyc - first) % POLL_DIV) == 0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  a;
        int          r;
        reset_n     = 1'b0;
        s_read      = 1'b0;
        s_write     = 1'b0;
        s_address   = '0;
        s_writedata = '0;
        in_port     = 4'b0101;
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b1;
        run_cmp = 1'b1;

        // Reset values, poll schedule, debounce accept, irq latency
        rd_check("rst_state", 2'd0, 32'd0);
        rd_check("rst_edge", 2'd1, 32'd0);
        rd_check("rst_mask", 2'd2, 32'd0);
        rd_check("rst_ctrl", 2'd3, 32'd1);
        bus_wr(2'd2, 32'd1);
        check("first_mread", 32'(m_read), 32'd1);
        mread_until(24, 5);
        check("irq_before", 32'(irq), 32'd0);
        tick();
        check("irq_rise", 32'(irq), 32'd1);
        rd_check("accept_state", 2'd0, 32'd5);
        rd_check("accept_edge", 2'd1, 32'd5);

        // W1C, then W1C colliding with a debounced change on bit 2
        bus_wr(2'd1, 32'd1);
        rd_check("w1c_edge", 2'd1, 32'd4);
        in_port = 4'b0001;
        wait_cyc(47);
        bus_wr(2'd1, 32'd5);
        rd_check("collide_edge", 2'd1, 32'd4);
        rd_check("collide_state", 2'd0, 32'd1);

        // Async reset in the middle of CAPTURE
        bus_wr(2'd2, 32'hF);
        bus_rd(2'd3, d);
        wait_cyc(54);
        check("pre_rst_irq", 32'(irq), 32'd1);
        check("pre_rst_rdata", s_readdata, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_now_mread", 32'(m_read), 32'd0);
        check("rst_now_irq", 32'(irq), 32'd0);
        check("rst_now_rdata", s_readdata, 32'd0);
        @(negedge clk);
        #1;
        in_port = 4'b0000;
        reset_n = 1'b1;
        rd_check("rst2_state", 2'd0, 32'd0);
        rd_check("rst2_edge", 2'd1, 32'd0);
        rd_check("rst2_mask", 2'd2, 32'd0);
        rd_check("rst2_ctrl", 2'd3, 32'd1);

        // Glitch of two polls is rejected
        in_port = 4'b1000;
        bus_wr(2'd2, 32'hF);
        wait_cyc(15);
        in_port = 4'b0000;
        wait_cyc(30);
        check("glitch_irq", 32'(irq), 32'd0);
        rd_check("glitch_state", 2'd0, 32'd0);
        rd_check("glitch_edge", 2'd1, 32'd0);

        // Disable during ISSUE, then re-enable
        in_port = 4'b0010;
        wait_cyc(37);
        check("dis_issue", 32'(m_read), 32'd1);
        bus_wr(2'd3, 32'd0);
        mread_until(60, 1000);
        bus_wr(2'd3, 32'd1);
        check("reen_quiet", 32'(m_read), 32'd0);
        mread_until(70, 66);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) in_port = 4'($urandom());
            r = int'($urandom_range(0, 99));
            if (i == 1500) begin
                reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end else if (r < 25) begin
                a = 2'($urandom());
                bus_rd(a, d);
            end else if (r < 35) begin
                a = 2'($urandom());
                d = $urandom();
                if (a == 2'd3) d[0] = ($urandom_range(0, 9) != 0);
                bus_wr(a, d);
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
